// File: rtl/sample_fifo.sv
// sample_fifo: single-clock synchronous FIFO holding {last, data} entries.
//
// Parameters
//   FIFO_DEPTH  address width; capacity is 2**FIFO_DEPTH entries (2..12)
//   FIFO_WIDTH  stored entry width; entry is {last, data}, data is FIFO_WIDTH-1 bits
//
// Ports
//   CLK, RST            rising-edge clock, asynchronous active-high reset
//   FIFO_WR_ENA/DATA/LAST  write request, data and last marker
//   FIFO_WR_FULL        count == capacity
//   FIFO_WR_ALM_FULL    free entries <= FIFO_WR_ALM_COUNT
//   FIFO_RD_ENA         read request
//   FIFO_RD_DATA/LAST   registered read word and its last marker
//   FIFO_RD_EMPTY       count == 0
//   FIFO_RD_ALM_EMPTY   count <= FIFO_RD_ALM_COUNT
//   FIFO_COUNT          occupancy count (present only with SAMPLE_FIFO_COUNT_EN)
//
// Optional feature macro: SAMPLE_FIFO_COUNT_EN adds the FIFO_COUNT output.
//
// Handshake: a write is accepted on a rising edge when FIFO_WR_ENA=1 and
// FIFO_WR_FULL=0; a read is accepted when FIFO_RD_ENA=1 and FIFO_RD_EMPTY=0.
// Requests that are not accepted are silently dropped; the producer/consumer
// are expected to watch the flags, which only change after an accepted edge.
module sample_fifo #(
  parameter int FIFO_DEPTH = 9,
  parameter int FIFO_WIDTH = 65
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FIFO_WR_ENA,
  input  logic [FIFO_WIDTH-2:0] FIFO_WR_DATA,
  input  logic                  FIFO_WR_LAST,
  output logic                  FIFO_WR_FULL,
  output logic                  FIFO_WR_ALM_FULL,
  input  logic [12:0]           FIFO_WR_ALM_COUNT,
  input  logic                  FIFO_RD_ENA,
  output logic [FIFO_WIDTH-2:0] FIFO_RD_DATA,
  output logic                  FIFO_RD_LAST,
  output logic                  FIFO_RD_EMPTY,
  output logic                  FIFO_RD_ALM_EMPTY,
  input  logic [12:0]           FIFO_RD_ALM_COUNT
`ifdef SAMPLE_FIFO_COUNT_EN
  ,
  output logic [FIFO_DEPTH:0]   FIFO_COUNT
`endif
);

  localparam int ENTRIES = 1 << FIFO_DEPTH;
  localparam logic [FIFO_DEPTH:0] CAP = (FIFO_DEPTH+1)'(ENTRIES);
  localparam logic [12:0] CAP13 = 13'(ENTRIES);

  logic [FIFO_WIDTH-1:0] mem [0:ENTRIES-1];
  logic [FIFO_DEPTH-1:0] wr_ptr;
  logic [FIFO_DEPTH-1:0] rd_ptr;
  logic [FIFO_DEPTH:0]   count;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [12:0]           count13;
  logic [12:0]           free13;

  // Flags decode the registered count only, so no ENA-to-flag path exists.
  assign FIFO_WR_FULL  = (count == CAP);
  assign FIFO_RD_EMPTY = (count == '0);

  assign wr_acc = FIFO_WR_ENA && !FIFO_WR_FULL;
  assign rd_acc = FIFO_RD_ENA && !FIFO_RD_EMPTY;

  // Thresholds are compared in a common 13-bit unsigned space; capacity
  // is at most 4096, so the free count never underflows.
  assign count13           = 13'(count);
  assign free13            = CAP13 - count13;
  assign FIFO_WR_ALM_FULL  = (free13 <= FIFO_WR_ALM_COUNT);
  assign FIFO_RD_ALM_EMPTY = (count13 <= FIFO_RD_ALM_COUNT);

`ifdef SAMPLE_FIFO_COUNT_EN
  assign FIFO_COUNT = count;
`endif

  // Storage is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      mem[wr_ptr] <= {FIFO_WR_LAST, FIFO_WR_DATA};
    end
  end

  // Pointers wrap naturally at FIFO_DEPTH bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + FIFO_DEPTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + FIFO_DEPTH'(1);
    end
  end

  // Simultaneous accepted write and read leave the count unchanged.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (wr_acc && !rd_acc) begin
      count <= count + (FIFO_DEPTH+1)'(1);
    end else if (rd_acc && !wr_acc) begin
      count <= count - (FIFO_DEPTH+1)'(1);
    end
  end

  // Output register holds its value until the next accepted read; a write
  // into an empty FIFO is never bypassed here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FIFO_RD_DATA <= '0;
      FIFO_RD_LAST <= 1'b0;
    end else if (rd_acc) begin
      {FIFO_RD_LAST, FIFO_RD_DATA} <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_sample_fifo.sv
module tb_sample_fifo;

  localparam int CAP = 512;
  localparam logic [63:0] BASE = 64'hFEDCBA98_76543210;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_ena;
  logic [63:0] wr_data;
  logic        wr_last;
  logic        full;
  logic        alm_full;
  logic [12:0] wr_alm;
  logic        rd_ena;
  logic [63:0] rd_data;
  logic        rd_last;
  logic        empty;
  logic        alm_empty;
  logic [12:0] rd_alm;
`ifdef SAMPLE_FIFO_COUNT_EN
  logic [9:0]  fifo_count;
`endif

  sample_fifo #(.FIFO_DEPTH(9), .FIFO_WIDTH(65)) dut (
    .CLK               (clk),
    .RST               (rst),
    .FIFO_WR_ENA       (wr_ena),
    .FIFO_WR_DATA      (wr_data),
    .FIFO_WR_LAST      (wr_last),
    .FIFO_WR_FULL      (full),
    .FIFO_WR_ALM_FULL  (alm_full),
    .FIFO_WR_ALM_COUNT (wr_alm),
    .FIFO_RD_ENA       (rd_ena),
    .FIFO_RD_DATA      (rd_data),
    .FIFO_RD_LAST      (rd_last),
    .FIFO_RD_EMPTY     (empty),
    .FIFO_RD_ALM_EMPTY (alm_empty),
    .FIFO_RD_ALM_COUNT (rd_alm)
`ifdef SAMPLE_FIFO_COUNT_EN
    ,
    .FIFO_COUNT        (fifo_count)
`endif
  );

  // Clock/reset
  always #5 clk = ~clk;

  // Scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [64:0] exp_q[$];
  int          mcnt     = 0;
  logic [64:0] exp_out  = '0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, update the expected queue from the
  // bench's own occupancy count, then check the registered read word.
  task automatic cycle(input logic wr, input logic rd, input logic [63:0] d, input logic l);
    logic wr_ok;
    logic rd_ok;
    wr_ok   = wr && (mcnt != CAP);
    rd_ok   = rd && (mcnt != 0);
    wr_ena  = wr;
    rd_ena  = rd;
    wr_data = d;
    wr_last = l;
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
    rd_ena = 1'b0;
    if (rd_ok) begin
      exp_out = exp_q.pop_front();
      mcnt--;
    end
    if (wr_ok) begin
      exp_q.push_back({l, d});
      mcnt++;
    end
    check("rd_word", {rd_last, rd_data}, exp_out);
`ifdef SAMPLE_FIFO_COUNT_EN
    check("count", 65'(fifo_count), 65'(mcnt));
`endif
  endtask

  initial begin
    rst     = 1'b1;
    wr_ena  = 1'b0;
    rd_ena  = 1'b0;
    wr_data = '0;
    wr_last = 1'b0;
    wr_alm  = 13'd128;
    rd_alm  = 13'd256;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 65'(empty), 65'd1);
    check("rst_alm_empty", 65'(alm_empty), 65'd1);
    check("rst_full", 65'(full), 65'd0);
    check("rst_alm_full", 65'(alm_full), 65'd0);
    check("rst_rd_data", 65'(rd_data), 65'd0);
    check("rst_rd_last", 65'(rd_last), 65'd0);
    rst = 1'b0;

    // Fill with no reads
    for (int k = 1; k <= CAP; k++) begin
      cycle(1'b1, 1'b0, BASE + 64'(k - 1), 1'b1);
      if (k == 1)   check("empty_after_w1", 65'(empty), 65'd0);
      if (k == 256) check("alm_empty_w256", 65'(alm_empty), 65'd1);
      if (k == 257) check("alm_empty_w257", 65'(alm_empty), 65'd0);
      if (k == 383) check("alm_full_w383", 65'(alm_full), 65'd0);
      if (k == 384) check("alm_full_w384", 65'(alm_full), 65'd1);
      if (k == 511) check("full_w511", 65'(full), 65'd0);
      if (k == 512) check("full_w512", 65'(full), 65'd1);
    end
    cycle(1'b1, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    check("full_after_drop", 65'(full), 65'd1);

    // Drain
    for (int j = 1; j <= CAP; j++) begin
      cycle(1'b0, 1'b1, '0, 1'b0);
      if (j == 1)   check("full_after_r1", 65'(full), 65'd0);
      if (j == 128) check("alm_full_r128", 65'(alm_full), 65'd1);
      if (j == 129) check("alm_full_r129", 65'(alm_full), 65'd0);
      if (j == 255) check("alm_empty_r255", 65'(alm_empty), 65'd0);
      if (j == 256) check("alm_empty_r256", 65'(alm_empty), 65'd1);
      if (j == 512) check("empty_r512", 65'(empty), 65'd1);
    end
    check("last_drained", {rd_last, rd_data}, {1'b1, BASE + 64'd511});
    cycle(1'b0, 1'b1, '0, 1'b0);
    check("empty_after_extra_rd", 65'(empty), 65'd1);

    // Write+read while empty: only the write lands, no bypass
    cycle(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
    check("wr_rd_empty_not_empty", 65'(empty), 65'd0);
    rd_alm = 13'd0;
    #1 check("alm_empty_thr0", 65'(alm_empty), 65'd0);
    rd_alm = 13'd1;
    #1 check("alm_empty_thr1", 65'(alm_empty), 65'd1);
    wr_alm = 13'd511;
    #1 check("alm_full_thr511", 65'(alm_full), 65'd1);
    wr_alm = 13'd510;
    #1 check("alm_full_thr510", 65'(alm_full), 65'd0);
    cycle(1'b0, 1'b1, '0, 1'b0);
    check("single_word", {rd_last, rd_data}, {1'b0, 64'h0123_4567_89AB_CDEF});
    check("empty_after_single", 65'(empty), 65'd1);

    // Concurrent streaming at half occupancy, across pointer wrap
    wr_alm = 13'd256;
    rd_alm = 13'd256;
    for (int k = 0; k < 256; k++) cycle(1'b1, 1'b0, 64'h1000 + 64'(k), k[0]);
    for (int c = 0; c < 1000; c++) begin
      cycle(1'b1, 1'b1, 64'h5000_0000 + 64'(c), (c % 3) == 0);
      if ((c % 100) == 0) begin
        check("stream_alm_empty", 65'(alm_empty), 65'd1);
        check("stream_alm_full", 65'(alm_full), 65'd1);
      end
    end
    for (int k = 0; k < 256; k++) cycle(1'b0, 1'b1, '0, 1'b0);
    check("stream_empty", 65'(empty), 65'd1);

    // Write+read while full: only the read lands
    for (int k = 0; k < CAP; k++) cycle(1'b1, 1'b0, 64'hA000 + 64'(k), 1'b1);
    check("refill_full", 65'(full), 65'd1);
    cycle(1'b1, 1'b1, 64'h0BAD, 1'b0);
    check("wr_rd_full_not_full", 65'(full), 65'd0);
    check("wr_rd_full_word", {rd_last, rd_data}, {1'b1, 64'hA000});
    cycle(1'b1, 1'b0, 64'hC0DE, 1'b0);
    check("full_again", 65'(full), 65'd1);
    for (int k = 0; k < CAP; k++) cycle(1'b0, 1'b1, '0, 1'b0);
    check("last_after_full_edge", {rd_last, rd_data}, {1'b0, 64'hC0DE});
    check("empty_after_full_edge", 65'(empty), 65'd1);

    // Mid-stream reset with 100 entries stored
    for (int k = 0; k < 100; k++) cycle(1'b1, 1'b0, 64'h7700 + 64'(k), 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_empty", 65'(empty), 65'd1);
    check("mid_rst_alm_empty", 65'(alm_empty), 65'd1);
    check("mid_rst_full", 65'(full), 65'd0);
    check("mid_rst_rd", {rd_last, rd_data}, 65'd0);
    exp_q.delete();
    mcnt    = 0;
    exp_out = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 64'h9900 + 64'(k), k[0]);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, '0, 1'b0);
    check("post_rst_last", {rd_last, rd_data}, {1'b0, 64'h9904});
    check("post_rst_empty", 65'(empty), 65'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
